fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the TSC CPU family.
- Replaces the single-instruction latch with a DEPTH-entry prefetch queue.
- Drives the memory read handshake (readM/address/data/inputReady) autonomously and tags each instruction with its PC.
- Supports PC redirect (jump/branch) with queue flush; the decode stage pops instructions via a valid/ready handshake.

Parameters:
- WORD_SIZE, 16, width of instruction, PC and data bus.
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 16'h0000, fetch PC loaded at reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- readM  output  1  memory read request; registered; level-held until accepted.
- address  output  WORD_SIZE  fetch PC presented to memory; registered; stable while readM=1.
- data  input  WORD_SIZE  instruction word from memory; valid when inputReady=1.
- inputReady  input  1  memory response strobe; accepted only in a cycle where readM=1.
- redirect  input  1  one-cycle pulse: discard queue, restart fetch at redirect_pc.
- redirect_pc  input  WORD_SIZE  new fetch PC.
- inst_valid  output  1  queue non-empty.
- inst  output  WORD_SIZE  head instruction.
- inst_pc  output  WORD_SIZE  PC of head instruction.
- inst_ready  input  1  consumer pops head when inst_valid & inst_ready.
- count  output  $clog2(DEPTH+1)  current occupancy.
- num_fetched  output  WORD_SIZE  accepted responses since reset; wraps modulo 2^WORD_SIZE.

Behaviour:
- Reset (synchronous, reset=1 at rising edge) sets:
  - state=IDLE, readM=0, address=RESET_PC, count=0, inst_valid=0, num_fetched=0.
  - inst and inst_pc undefined-but-stable; drive 0.
  - Reset dominates redirect and inputReady in the same cycle.
- Accept = readM & inputReady; push = accept & ~redirect; pop = inst_valid & inst_ready & ~redirect.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged; ordering is preserved.
- FSM, 3 states:
  - IDLE: readM=0. Go to REQ when count_next < DEPTH.
  - REQ: readM=1. On push: address <= address+1 (word addressing, wraps at 2^WORD_SIZE). Stay in REQ if count_next < DEPTH, else go to IDLE.
  - FLUSH: readM=0 for exactly one cycle after a redirect, then REQ (queue is empty).
  - From any state, redirect=1 gives: count <= 0, head/tail pointers <= 0, address <= redirect_pc, state <= FLUSH.
  - A response arriving in the redirect cycle is dropped and not counted.
- Queue storage is a circular buffer of {pc, instr}; head/tail pointers use $clog2(DEPTH) bits and wrap naturally.
- Timing:
  - Pushed entry is visible on inst/inst_valid the cycle after accept; zero-latency bypass is not provided.
  - Minimum reset-to-first-readM is 1 cycle; redirect-to-readM is 2 cycles.
  - Back-to-back inputReady in REQ gives one accept per cycle, with address incrementing each cycle.
- Full: readM is never 1 while count==DEPTH. When the last slot fills, readM drops the next cycle unless a pop occurs in the same cycle.
- inputReady while readM=0 is ignored; the bench flags it as a protocol error (assertion).
- num_fetched increments on every push.

Decomposition:
- Shared package/header (alongside opcodes definitions):
  - WORD_SIZE default.
  - FSM state encodings FQ_IDLE, FQ_REQ, FQ_FLUSH.
  - Queue entry struct/width macro {pc, instr}.
- One natural sub-module: fq_ring_buffer, a parametrised synchronous circular buffer with push/pop/clear, full/empty and count.
- The FSM and address logic remain in fetch_queue.

Test Plan:
1. Reset, then memory returns inputReady one cycle after each readM with data=address^16'hA5A5, inst_ready=0 → addresses 0,1,2,3 fetched; readM=0 with count=4; inst=16'hA5A5, inst_pc=0.
2. Queue full, then inst_ready=1 for 1 cycle → one pop; readM reasserts next cycle at address 4; inst_pc becomes 1.
3. Continuous inputReady with inst_ready=1 every cycle → steady state of one fetch/one pop per cycle; count constant; inst_pc sequence 0,1,2,... with no gaps.
4. redirect=1, redirect_pc=16'h0040 in the same cycle as an accept with count=2 → response dropped; count=0, inst_valid=0 next cycle; readM=0 for one cycle, then readM=1 with address=16'h0040; num_fetched unchanged by the dropped response.
5. Fetch across wrap: redirect_pc=16'hFFFE, 3 responses → inst_pc sequence FFFE, FFFF, 0000.
6. reset asserted mid-REQ with inputReady=1 → next cycle readM=0, count=0, address=RESET_PC, num_fetched=0; the response is not queued.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch prefetch queue.
package fetch_queue_pkg;

    localparam int FQ_WORD_SIZE = 16;

    typedef enum logic [1:0] {
        FQ_IDLE  = 2'd0,
        FQ_REQ   = 2'd1,
        FQ_FLUSH = 2'd2
    } fq_state_e;

    // A queue entry packs {pc, instr}, so it is twice the word width.
    function automatic int fq_entry_width(input int word_size);
        return 2 * word_size;
    endfunction

endpackage

// File: rtl/fq_ring_buffer.sv
// Synchronous circular buffer with push/pop/clear; reads the head entry combinationally.
module fq_ring_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Guard push/pop against full/empty so pointers can never overrun.
    always_comb begin
        do_push_s = push & (count_r != DEPTH_C);
        do_pop_s  = pop & (count_r != {CW{1'b0}});
    end

    // Storage, pointers and occupancy; clear keeps storage but empties the ring.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (clear) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[tail_r] <= wdata;
                tail_r        <= tail_r + PW'(1'b1);
            end
            if (do_pop_s) begin
                head_r <= head_r + PW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[head_r];
    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: drives the memory read handshake and queues {pc, instr}
// entries for the decode stage, with PC redirect and flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                   WORD_SIZE = FQ_WORD_SIZE,
    parameter int                   DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 16'h0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       readM,
    output logic [WORD_SIZE-1:0]       address,
    input  logic [WORD_SIZE-1:0]       data,
    input  logic                       inputReady,
    input  logic                       redirect,
    input  logic [WORD_SIZE-1:0]       redirect_pc,
    output logic                       inst_valid,
    output logic [WORD_SIZE-1:0]       inst,
    output logic [WORD_SIZE-1:0]       inst_pc,
    input  logic                       inst_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WORD_SIZE-1:0]       num_fetched
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = fq_entry_width(WORD_SIZE);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fq_state_e            state_r;
    fq_state_e            state_next_s;
    logic                 readm_r;
    logic [WORD_SIZE-1:0] address_r;
    logic [WORD_SIZE-1:0] num_fetched_r;
    logic                 push_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 empty_s;
    logic [CW-1:0]        count_s;
    logic [CW-1:0]        count_next_s;
    logic [EW-1:0]        rdata_s;

    // Handshake qualification; a redirect cycle neither stores nor pops.
    always_comb begin
        push_s       = readm_r & inputReady & ~redirect & ~full_s;
        pop_s        = ~empty_s & inst_ready & ~redirect;
        count_next_s = count_s + CW'(push_s) - CW'(pop_s);
    end

    // Next-state: keep requesting while the queue will still have room.
    always_comb begin
        state_next_s = state_r;
        if (redirect) begin
            state_next_s = FQ_FLUSH;
        end else begin
            case (state_r)
                FQ_IDLE, FQ_REQ: begin
                    if (count_next_s < DEPTH_C) begin
                        state_next_s = FQ_REQ;
                    end else begin
                        state_next_s = FQ_IDLE;
                    end
                end
                FQ_FLUSH: state_next_s = FQ_REQ;
                default:  state_next_s = FQ_IDLE;
            endcase
        end
    end

    // State, registered read request, fetch PC and fetch counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= FQ_IDLE;
            readm_r       <= 1'b0;
            address_r     <= RESET_PC;
            num_fetched_r <= {WORD_SIZE{1'b0}};
        end else begin
            state_r <= state_next_s;
            readm_r <= (state_next_s == FQ_REQ);
            if (redirect) begin
                address_r <= redirect_pc;
            end else if (push_s) begin
                address_r <= address_r + WORD_SIZE'(1'b1);
            end else begin
                address_r <= address_r;
            end
            if (push_s) begin
                num_fetched_r <= num_fetched_r + WORD_SIZE'(1'b1);
            end
        end
    end

    fq_ring_buffer #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk   (clk),
        .reset (reset),
        .clear (redirect),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({address_r, data}),
        .rdata (rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign readM       = readm_r;
    assign address     = address_r;
    assign inst_valid  = ~empty_s;
    assign inst        = rdata_s[WORD_SIZE-1:0];
    assign inst_pc     = rdata_s[EW-1:WORD_SIZE];
    assign count       = count_s;
    assign num_fetched = num_fetched_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model checked every cycle.
module tb_fetch_queue;
    localparam int WS    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          readM;
    logic [WS-1:0] address;
    logic [WS-1:0] data;
    logic          inputReady;
    logic          redirect;
    logic [WS-1:0] redirect_pc;
    logic          inst_valid;
    logic [WS-1:0] inst;
    logic [WS-1:0] inst_pc;
    logic          inst_ready;
    logic [CW-1:0] count;
    logic [WS-1:0] num_fetched;

    fetch_queue #(
        .WORD_SIZE (WS),
        .DEPTH     (DEPTH),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .readM       (readM),
        .address     (address),
        .data        (data),
        .inputReady  (inputReady),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .count       (count),
        .num_fetched (num_fetched)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of {pc, instr}, a fetch PC and a fetch counter.
    logic [31:0]   m_q[$];
    logic [WS-1:0] m_addr = 16'h0000;
    logic [WS-1:0] m_nf   = 16'h0000;
    logic          m_readm = 1'b0;
    bit            m_live  = 1'b0;

    always @(posedge clk) begin
        bit acc, push, pop;
        if (reset) begin
            m_q.delete();
            m_addr  = 16'h0000;
            m_nf    = 16'h0000;
            m_readm = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            acc  = m_readm && inputReady;
            push = acc && !redirect;
            pop  = (m_q.size() > 0) && inst_ready && !redirect;
            if (redirect) begin
                m_q.delete();
                m_addr  = redirect_pc;
                m_readm = 1'b0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back({m_addr, data});
                    m_addr = m_addr + 16'h0001;
                    m_nf   = m_nf + 16'h0001;
                end
                m_readm = (m_q.size() < DEPTH);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("readM", {31'd0, readM}, {31'd0, m_readm});
            chk("address", {16'd0, address}, {16'd0, m_addr});
            chk("count", {29'd0, count}, m_q.size());
            chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_q.size() != 0});
            chk("num_fetched", {16'd0, num_fetched}, {16'd0, m_nf});
            chk("no_req_when_full", {31'd0, readM & (count == CW'(DEPTH))}, 32'd0);
            if (m_q.size() != 0) begin
                chk("inst", {16'd0, inst}, {16'd0, m_q[0][15:0]});
                chk("inst_pc", {16'd0, inst_pc}, {16'd0, m_q[0][31:16]});
            end
        end
    end

    // Memory answers only while readM is high, with data = address ^ A5A5.
    task automatic step(input logic rst, input logic ir, input logic rdy,
                        input logic rd, input logic [WS-1:0] rpc);
        reset       = rst;
        inputReady  = ir & (readM === 1'b1);
        data        = address ^ 16'hA5A5;
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; inputReady = 1'b0; data = 16'h0000;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("rst_readM", {31'd0, readM}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_inst", {16'd0, inst}, 32'd0);

        // Fill: responses every other cycle, consumer stalled.
        for (int i = 0; i < 12; i++) step(1'b0, i[0], 1'b0, 1'b0, 16'h0000);
        chk("t1_count", {29'd0, count}, 32'd4);
        chk("t1_readM", {31'd0, readM}, 32'd0);
        chk("t1_inst", {16'd0, inst}, 32'h0000A5A5);
        chk("t1_inst_pc", {16'd0, inst_pc}, 32'd0);
        chk("t1_num_fetched", {16'd0, num_fetched}, 32'd4);

        // One pop from full re-opens the request at address 4.
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("t2_readM", {31'd0, readM}, 32'd1);
        chk("t2_address", {16'd0, address}, 32'd4);
        chk("t2_inst_pc", {16'd0, inst_pc}, 32'd1);
        chk("t2_inst", {16'd0, inst}, 32'h0000A5A4);

        // Streaming: one fetch and one pop per cycle.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        chk("t3_count", {29'd0, count}, 32'd3);
        chk("t3_inst_pc", {16'd0, inst_pc}, 32'd11);
        chk("t3_address", {16'd0, address}, 32'd14);

        // Redirect coinciding with an accept at count=2.
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("t4_pre_count", {29'd0, count}, 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0040);
        chk("t4_count", {29'd0, count}, 32'd0);
        chk("t4_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("t4_readM_flush", {31'd0, readM}, 32'd0);
        chk("t4_num_fetched", {16'd0, num_fetched}, 32'd14);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("t4_readM", {31'd0, readM}, 32'd1);
        chk("t4_address", {16'd0, address}, 32'h00000040);

        // Fetch across the top of the address space.
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("t5_pc0", {16'd0, inst_pc}, 32'h0000FFFE);
        chk("t5_address", {16'd0, address}, 32'h00000001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("t5_pc1", {16'd0, inst_pc}, 32'h0000FFFF);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("t5_pc2", {16'd0, inst_pc}, 32'h00000000);
        chk("t5_inst2", {16'd0, inst}, 32'h0000A5A5);

        // Reset during an active request with a response arriving.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("t6_readM", {31'd0, readM}, 32'd0);
        chk("t6_count", {29'd0, count}, 32'd0);
        chk("t6_address", {16'd0, address}, 32'd0);
        chk("t6_num_fetched", {16'd0, num_fetched}, 32'd0);
        chk("t6_inst_valid", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
